serializer_tx: RTL and testbench
================================

Name: serializer_tx

Overview:
- Transmit-side counterpart of the team's bit-serial deserializer link.
- Accepts parallel bytes into a small FIFO and shifts each one out MSB first on data_out.
- Each bit is qualified by a write_out strobe held for BIT_HOLD cycles, followed by BIT_GAP idle cycles.
- This matches the per-bit write framing the deserializer samples, so serializer_tx can drive that block's data_in and write_in directly.

Parameters:
- WIDTH, 8, bits per word; transmission is MSB first.
- DEPTH, 4, input FIFO entries; must be a power of 2 and >= 2.
- BIT_HOLD, 10, cycles write_out is held high per bit; must be >= 1.
- BIT_GAP, 10, cycles write_out is held low after each bit; must be >= 1.

Ports:
- clock1M  input  1  system clock; 1 MHz nominal; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- data_in  input  WIDTH  parallel word to enqueue.
- enqueue_in  input  1  enqueue request; sampled on the rising edge.
- ready_out  output  1  FIFO not full (count < DEPTH).
- data_out  output  1  serial bit, valid while write_out = 1.
- write_out  output  1  bit strobe toward the receiver.
- busy_out  output  1  FSM not in IDLE.
- count_out  output  $clog2(DEPTH+1)  FIFO occupancy.

Behaviour:
- Reset values (reset = 0): data_out = 0, write_out = 0, busy_out = 0, count_out = 0, FSM = IDLE, FIFO pointers = 0. ready_out = 1 (it is combinational from count).
- Enqueue: accepted at a rising edge when enqueue_in = 1 and ready_out = 1; data_in is written at the tail.
  - enqueue_in while full: ignored; no state change; no error flag.
  - ready_out is derived from the registered count, so a pop in the same edge does not make room for that edge's enqueue.
- Simultaneous push and pop in one edge: both occur; count is unchanged.
- FIFO pointers wrap modulo DEPTH.
- FSM states: IDLE, HOLD, GAP.
  - IDLE: data_out = 0, write_out = 0. If count > 0 at an edge: pop head into the shift register, set bit index = WIDTH-1, drive data_out = MSB and write_out = 1, go to HOLD.
  - HOLD: write_out = 1 and data_out stable for exactly BIT_HOLD cycles; then write_out = 0 (data_out keeps its value), go to GAP.
  - GAP: write_out = 0 for exactly BIT_GAP cycles. At the last GAP edge:
    - bit index > 0: decrement, drive the next bit, write_out = 1, go to HOLD.
    - else if count > 0: pop the next word, load its MSB, go to HOLD (back-to-back, no extra idle cycle).
    - else: data_out = 0, go to IDLE.
- Latency: enqueue accepted at edge E0 into an empty FIFO while IDLE → write_out rises at E1.
- Per-word time: WIDTH*(BIT_HOLD+BIT_GAP) cycles, which is 160 with defaults.
- A single cycle counter sized for max(BIT_HOLD, BIT_GAP) sequences HOLD and GAP; it reloads on every state change.
- busy_out = (state != IDLE), registered.
- Reset mid-operation: all outputs drop asynchronously and the FIFO contents are discarded. After reset release the block stays IDLE until a new enqueue.
- No glitches: data_out and write_out are driven directly from flops.

Test Plan:
1. Hold reset = 0 for 10 cycles with enqueue_in = 1 → data_out = 0, write_out = 0, busy_out = 0, count_out = 0, ready_out = 1; no word accepted.
2. Enqueue 0xA5 once → write_out rises at E1; data_out sampled at each write_out rise = 1,0,1,0,0,1,0,1; each pulse exactly 10 cycles high and 10 cycles low; busy_out falls 160 cycles after E1.
3. Enqueue 0xA5 then 0x3C on consecutive edges → 16 strobes with no extra idle cycle between words; second word bits = 0,0,1,1,1,1,0,0.
4. Enqueue 6 words 0x01..0x06 on 6 consecutive edges:
   - Pushes at E0..E4; the pop at E1 keeps count at 1.
   - ready_out = 0 after E4; 0x06 at E5 is ignored; count_out peaks at 4.
   - Serial output is 0x01..0x05 only; afterward count_out = 0 and busy_out = 0.
5. Enqueue 0xFF, then drive reset = 0 during the 3rd bit's HOLD → write_out, data_out and busy_out go to 0 immediately; count_out = 0. After release, no strobes occur for 200 cycles.
6. Enqueue 0x3C and capture on the falling edge of write_out (LSB-to-MSB order reversed) → reconstructed word = 0x3C; total write_out pulses = 8.

Source files
------------

// File: rtl/serializer_tx.sv
// Bit-serial transmitter: a small byte FIFO feeding an MSB-first shifter that frames
// each bit as BIT_HOLD strobe-high cycles followed by BIT_GAP strobe-low cycles.
module serializer_tx #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned BIT_HOLD = 10,
    parameter int unsigned BIT_GAP  = 10
) (
    input  logic                         clock1M,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             data_in,
    input  logic                         enqueue_in,
    output logic                         ready_out,
    output logic                         data_out,
    output logic                         write_out,
    output logic                         busy_out,
    output logic [$clog2(DEPTH+1)-1:0]   count_out
);

    localparam int unsigned PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_OUT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned CNT_MAX   = (BIT_HOLD > BIT_GAP) ? BIT_HOLD : BIT_GAP;
    localparam int unsigned CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_OUT_W-1:0] count_q, count_d;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [WIDTH-1:0]     shift_q, shift_d;
    logic                 data_q, data_d;
    logic                 write_q, write_d;
    logic                 busy_q, busy_d;

    logic                 push;
    logic                 pop;
    logic [WIDTH-1:0]     head_w;

    assign ready_out = (count_q < CNT_OUT_W'(DEPTH));
    assign push      = enqueue_in && ready_out;
    assign head_w    = mem_q[rd_ptr_q];

    assign data_out  = data_q;
    assign write_out = write_q;
    assign busy_out  = busy_q;
    assign count_out = count_q;

    // FIFO storage carries no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clock1M) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    // Next-state logic for the bit sequencer and FIFO bookkeeping.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        data_d   = data_q;
        write_d  = write_q;
        pop      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                data_d  = 1'b0;
                write_d = 1'b0;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = head_w;
                    idx_d   = IDX_W'(WIDTH - 1);
                    data_d  = head_w[WIDTH-1];
                    write_d = 1'b1;
                    cnt_d   = CNT_W'(BIT_HOLD - 1);
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    write_d = 1'b0;
                    cnt_d   = CNT_W'(BIT_GAP - 1);
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (idx_q != '0) begin
                    idx_d   = idx_q - IDX_W'(1);
                    data_d  = shift_q[idx_d];
                    write_d = 1'b1;
                    cnt_d   = CNT_W'(BIT_HOLD - 1);
                    state_d = ST_HOLD;
                end else if (count_q != '0) begin
                    // Back-to-back word: reload straight into HOLD without an idle cycle.
                    pop     = 1'b1;
                    shift_d = head_w;
                    idx_d   = IDX_W'(WIDTH - 1);
                    data_d  = head_w[WIDTH-1];
                    write_d = 1'b1;
                    cnt_d   = CNT_W'(BIT_HOLD - 1);
                    state_d = ST_HOLD;
                end else begin
                    data_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                data_d  = 1'b0;
                write_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);

        wr_ptr_d = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_OUT_W'(1);
            2'b01:   count_d = count_q - CNT_OUT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock1M or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            data_q   <= 1'b0;
            write_q  <= 1'b0;
            busy_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            write_q  <= write_d;
            busy_q   <= busy_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_serializer_tx.sv
// Scoreboard bench for serializer_tx: a word-level timing model predicts FIFO occupancy,
// busy and acceptance; a monitor rebuilds words from the strobes and checks framing.
module tb_serializer_tx;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned HOLD     = 10;
    localparam int unsigned GAP      = 10;
    localparam int unsigned WORD_CYC = WIDTH * (HOLD + GAP);
    localparam int unsigned CW       = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic             enq = 1'b0;
    logic             ready_out;
    logic             data_out;
    logic             write_out;
    logic             busy_out;
    logic [CW-1:0]    count_out;

    serializer_tx #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .BIT_HOLD(HOLD),
        .BIT_GAP (GAP)
    ) dut (
        .clock1M   (clk),
        .reset     (rst_n),
        .data_in   (data_in),
        .enqueue_in(enq),
        .ready_out (ready_out),
        .data_out  (data_out),
        .write_out (write_out),
        .busy_out  (busy_out),
        .count_out (count_out)
    );

    always #5 clk = ~clk;

    int chk  = 0;
    int errs = 0;
    int cyc  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Reference model: a word occupies the line for WORD_CYC edges after it is popped;
    // the next word pops on the final edge of the current one, or at once when idle.
    logic [WIDTH-1:0] m_fifo[$];
    logic [WIDTH-1:0] exp_q[$];
    int               m_rem = 0;
    int               m_sz;
    bit               m_pop;
    bit               m_push;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_fifo.delete();
            exp_q.delete();
            m_rem = 0;
        end else begin
            m_sz   = m_fifo.size();
            m_pop  = (m_sz > 0) && (m_rem <= 1);
            m_push = enq && (m_sz < DEPTH);
            if (m_rem > 0) m_rem--;
            if (m_pop) begin
                void'(m_fifo.pop_front());
                m_rem = WORD_CYC;
            end
            if (m_push) begin
                m_fifo.push_back(data_in);
                exp_q.push_back(data_in);
            end
        end
    end

    // Monitor: framing, word reassembly and per-cycle status comparison.
    int               rises[$];
    bit               rise_bits[$];
    int               n_fall = 0;
    int               words_rx = 0;
    int               peak = 0;
    int               hi_len = 0;
    int               lo_len = 0;
    int               nbits = 0;
    bit               prev_w = 1'b0;
    bit               cur_bit = 1'b0;
    bit               had_word = 1'b0;
    logic [WIDTH-1:0] word = '0;
    logic [WIDTH-1:0] last_word = '0;
    logic [WIDTH-1:0] exp_word;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_w   = 1'b0;
            nbits    = 0;
            hi_len   = 0;
            lo_len   = 0;
            had_word = 1'b0;
        end else begin
            check("count", 32'(count_out), 32'(m_fifo.size()));
            check("ready", 32'(ready_out), 32'(m_fifo.size() < DEPTH));
            check("busy", 32'(busy_out), 32'(m_rem > 0));
            if (m_rem == 0) begin
                check("idle_write", 32'(write_out), 32'd0);
                check("idle_data", 32'(data_out), 32'd0);
            end
            if (int'(count_out) > peak) peak = int'(count_out);

            if (write_out && !prev_w) begin
                if (nbits > 0) check("gap_len", 32'(lo_len), 32'(GAP));
                else if (had_word) check("gap_min", 32'(lo_len >= GAP), 32'd1);
                cur_bit = data_out;
                rises.push_back(cyc);
                rise_bits.push_back(data_out);
                hi_len = 1;
            end else if (write_out) begin
                hi_len++;
                check("hold_data", 32'(data_out), 32'(cur_bit));
            end else if (prev_w) begin
                check("hold_len", 32'(hi_len), 32'(HOLD));
                check("fall_data", 32'(data_out), 32'(cur_bit));
                word = {word[WIDTH-2:0], data_out};
                nbits++;
                n_fall++;
                lo_len = 1;
                if (nbits == WIDTH) begin
                    check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        exp_word = exp_q.pop_front();
                        check("sb_word", 32'(word), 32'(exp_word));
                    end
                    last_word = word;
                    words_rx++;
                    nbits    = 0;
                    had_word = 1'b1;
                end
            end else begin
                lo_len++;
            end
            prev_w = write_out;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] w);
        data_in = w;
        enq     = 1'b1;
        tick();
        enq     = 1'b0;
    endtask

    // Waits for the model and DUT to go idle; returns the cycle of the first idle sample.
    task automatic wait_drain(input int bound, output int t);
        bit done;
        done = 1'b0;
        t    = -1;
        for (int i = 0; i < bound && !done; i++) begin
            @(negedge clk);
            if (!busy_out && m_rem == 0 && m_fifo.size() == 0) begin
                done = 1'b1;
                t    = cyc;
            end
        end
        if (!done) check("drain_timeout", 32'(busy_out), 32'd0);
    endtask

    task automatic wait_rises(input int n, input int bound);
        bit done;
        done = 1'b0;
        for (int i = 0; i < bound && !done; i++) begin
            @(negedge clk);
            if (rises.size() >= n) done = 1'b1;
        end
        if (!done) check("rise_timeout", 32'(rises.size()), 32'(n));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    int               t0;
    int               tend;
    int               w0;
    int               n0;
    logic [WIDTH-1:0] pat;

    initial begin
        // Test 1: reset held with enqueue asserted.
        rst_n   = 1'b0;
        enq     = 1'b1;
        data_in = 8'h5A;
        repeat (10) @(posedge clk);
        #1;
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_write", 32'(write_out), 32'd0);
        check("rst_busy", 32'(busy_out), 32'd0);
        check("rst_count", 32'(count_out), 32'd0);
        check("rst_ready", 32'(ready_out), 32'd1);
        enq = 1'b0;
        #2 rst_n = 1'b1;
        repeat (3) tick();
        check("post_rst_count", 32'(count_out), 32'd0);
        check("post_rst_busy", 32'(busy_out), 32'd0);

        // Test 2: single word 0xA5, latency, bit order and word duration.
        rises.delete();
        rise_bits.delete();
        t0 = cyc;
        send(8'hA5);
        wait_rises(1, 10);
        if (rises.size() > 0) check("latency", 32'(rises[0] - t0), 32'd2);
        wait_drain(400, tend);
        if (rises.size() > 0) check("busy_fall", 32'(tend - rises[0]), 32'(WORD_CYC));
        check("a5_strobes", 32'(rises.size()), 32'(WIDTH));
        pat = 8'hA5;
        for (int i = 0; i < WIDTH && i < rise_bits.size(); i++)
            check("a5_bit", 32'(rise_bits[i]), 32'(pat[WIDTH-1-i]));

        // Test 3: two words back to back.
        rises.delete();
        rise_bits.delete();
        data_in = 8'hA5;
        enq     = 1'b1;
        tick();
        data_in = 8'h3C;
        tick();
        enq = 1'b0;
        wait_drain(600, tend);
        check("b2b_strobes", 32'(rises.size()), 32'(2 * WIDTH));
        if (rises.size() >= 2 * WIDTH) begin
            check("b2b_word_gap", 32'(rises[WIDTH] - rises[0]), 32'(WORD_CYC));
            check("b2b_bit_pitch", 32'(rises[1] - rises[0]), 32'(HOLD + GAP));
        end
        pat = 8'h3C;
        for (int i = 0; i < WIDTH && (WIDTH + i) < rise_bits.size(); i++)
            check("3c_bit", 32'(rise_bits[WIDTH+i]), 32'(pat[WIDTH-1-i]));

        // Test 4: overfill; sixth word must be dropped.
        peak = 0;
        w0   = words_rx;
        for (int i = 1; i <= 6; i++) begin
            data_in = 8'(i);
            enq     = 1'b1;
            if (i == 6) check("ready_full", 32'(ready_out), 32'd0);
            tick();
        end
        enq = 1'b0;
        wait_drain(1500, tend);
        check("peak_count", 32'(peak), 32'(DEPTH));
        check("words_sent", 32'(words_rx - w0), 32'd5);
        check("drain_count", 32'(count_out), 32'd0);
        check("drain_busy", 32'(busy_out), 32'd0);

        // Test 5: reset during the third bit's HOLD.
        rises.delete();
        send(8'hFF);
        wait_rises(3, 100);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_write", 32'(write_out), 32'd0);
        check("mid_rst_data", 32'(data_out), 32'd0);
        check("mid_rst_busy", 32'(busy_out), 32'd0);
        check("mid_rst_count", 32'(count_out), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        n0 = rises.size();
        repeat (200) tick();
        check("post_rst_strobes", 32'(rises.size() - n0), 32'd0);
        check("post_rst_idle", 32'(busy_out), 32'd0);

        // Test 6: reconstruct 0x3C from falling-edge captures.
        n0 = n_fall;
        send(8'h3C);
        wait_drain(400, tend);
        check("fall_word", 32'(last_word), 32'h3C);
        check("fall_pulses", 32'(n_fall - n0), 32'(WIDTH));

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            enq     = ($urandom_range(0, 7) == 0);
            data_in = WIDTH'($urandom);
            tick();
        end
        enq = 1'b0;
        wait_drain(2500, tend);
        check("sb_empty_end", 32'(exp_q.size()), 32'd0);
        check("end_count", 32'(count_out), 32'd0);

        $display("CHECKS %0d ERRORS %0d", chk, errs);
        $finish;
    end

endmodule
